// File: rtl/inst_loader.sv
// ---------------------------------------------------------------------------
// inst_loader
//
// Boot-time loader for the 32 x 20-bit instruction memory. Bytes arrive from
// a byte-serial source over a valid/ready handshake; every three bytes are
// packed little-endian into one 20-bit instruction word. Each word is then
// written to the memory in a single WRITE cycle at consecutive addresses
// starting at 0. Progress and status go back to the system controller.
//
// Ports
//   clk                 rising-edge clock for all logic
//   rst                 synchronous, active-high reset
//   start               begin a load (only looked at while idle)
//   load_len[5:0]       number of words to load, captured with start
//   byte_valid          byte_data carries a valid byte
//   byte_data[7:0]      incoming byte
//   byte_ready          loader consumes a byte on this cycle's edge
//   mem_enable          memory enable, high only during WRITE
//   mem_read_writenot   0 selects write, 1 otherwise
//   mem_write_address   target word address
//   mem_in_data         word being stored
//   busy                high whenever the loader is not idle
//   done                single-cycle pulse at the end of a load
//   error               sticky status: illegal length or non-zero high nibble
//   words_loaded[5:0]   words written during the current/last load
// ---------------------------------------------------------------------------
module inst_loader #(
   parameter int DATA_W = 20,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [5:0]        load_len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_enable,
   output logic              mem_read_writenot,
   output logic [ADDR_W-1:0] mem_write_address,
   output logic [DATA_W-1:0] mem_in_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [5:0]        words_loaded
);

   typedef enum logic [2:0] {
      IDLE,
      B0,
      B1,
      B2,
      WRITE,
      DONE
   } state_t;

   localparam logic [5:0]        MAX_LEN  = 6'(DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state;
   state_t            state_next;

   // Captured load length, next write address and the low two bytes of the
   // word currently being assembled.
   logic [5:0]        len_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       word_lo_q;

   // Registered copies of the memory write port and status outputs.
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_data_q;
   logic              error_q;
   logic [5:0]        words_q;

   logic              byte_accept;
   logic              len_legal;
   logic [5:0]        words_inc;
   logic              last_word;

   // A length of zero or more than the memory depth is rejected up front so
   // that nothing is ever written and the address counter can never wrap.
   assign len_legal   = (load_len != 6'd0) && (load_len <= MAX_LEN);
   assign byte_accept = byte_valid & byte_ready;
   assign words_inc   = words_q + 6'd1;
   assign last_word   = (words_inc == len_q);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic plus the state-decoded handshake and memory controls.
   always_comb begin
      state_next        = state;
      byte_ready        = 1'b0;
      mem_enable        = 1'b0;
      mem_read_writenot = 1'b1;
      busy              = 1'b1;
      done              = 1'b0;

      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = len_legal ? B0 : DONE;
            end
         end

         B0: begin
            byte_ready = 1'b1;
            if (byte_accept) begin
               state_next = B1;
            end
         end

         B1: begin
            byte_ready = 1'b1;
            if (byte_accept) begin
               state_next = B2;
            end
         end

         B2: begin
            byte_ready = 1'b1;
            if (byte_accept) begin
               state_next = WRITE;
            end
         end

         WRITE: begin
            mem_enable        = 1'b1;
            mem_read_writenot = 1'b0;
            state_next        = last_word ? DONE : B0;
         end

         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: length capture, byte packing, address/word counters and the
   // sticky error flag. The memory address/data registers are loaded on the
   // edge that accepts the third byte, so they are stable for the whole
   // WRITE cycle and keep their value afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q      <= 6'd0;
         addr_q     <= '0;
         word_lo_q  <= 16'd0;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         error_q    <= 1'b0;
         words_q    <= 6'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_q   <= load_len;
                  addr_q  <= '0;
                  words_q <= 6'd0;
                  error_q <= ~len_legal;
               end
            end

            B0: begin
               if (byte_accept) begin
                  word_lo_q[7:0] <= byte_data;
               end
            end

            B1: begin
               if (byte_accept) begin
                  word_lo_q[15:8] <= byte_data;
               end
            end

            // Only the low nibble of the third byte belongs to the word; a
            // non-zero high nibble marks a corrupt image but the word is
            // still stored so the address sequence stays intact.
            B2: begin
               if (byte_accept) begin
                  mem_addr_q <= addr_q;
                  mem_data_q <= {byte_data[3:0], word_lo_q};
                  if (byte_data[7:4] != 4'd0) begin
                     error_q <= 1'b1;
                  end
               end
            end

            // The final word of a full-depth load leaves addr_q at the top
            // address; there is no following write, so it is not advanced.
            WRITE: begin
               words_q <= words_inc;
               if (!last_word) begin
                  addr_q <= addr_q + ADDR_ONE;
               end
            end

            default: begin
            end
         endcase
      end
   end

   assign mem_write_address = mem_addr_q;
   assign mem_in_data       = mem_data_q;
   assign error             = error_q;
   assign words_loaded      = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_loader
//
// Self-checking bench for inst_loader. Expected memory writes are queued as
// each load is set up and popped by a monitor whenever the loader drives a
// write cycle. Load timing, status outputs and reset behaviour are compared
// directly against values computed here.
// ---------------------------------------------------------------------------
module tb_inst_loader;

   typedef struct packed {
      logic [4:0]  addr;
      logic [19:0] data;
   } exp_write_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  load_len;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_enable;
   logic        mem_read_writenot;
   logic [4:0]  mem_write_address;
   logic [19:0] mem_in_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [5:0]  words_loaded;

   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          start_cyc  = 0;
   int          en_count   = 0;
   int          done_count = 0;
   int          done_cyc   = 0;
   logic        done_err   = 1'b0;
   logic [5:0]  done_words = 6'd0;

   exp_write_t  sb_q[$];
   logic [7:0]  byte_q[$];

   inst_loader dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .load_len          (load_len),
      .byte_valid        (byte_valid),
      .byte_data         (byte_data),
      .byte_ready        (byte_ready),
      .mem_enable        (mem_enable),
      .mem_read_writenot (mem_read_writenot),
      .mem_write_address (mem_write_address),
      .mem_in_data       (mem_in_data),
      .busy              (busy),
      .done              (done),
      .error             (error),
      .words_loaded      (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  tag, observed, expected, cyc);
      end
   endtask

   // Monitor: scoreboard the memory writes and record each done pulse.
   always @(negedge clk) begin
      exp_write_t e;
      if (!rst) begin
         checkOutput("rw_select", {31'd0, mem_read_writenot}, {31'd0, ~mem_enable});
         if (mem_enable) begin
            en_count++;
            checkOutput("ready_in_write", {31'd0, byte_ready}, 32'd0);
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_write", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("write_addr", {27'd0, mem_write_address}, {27'd0, e.addr});
               checkOutput("write_data", {12'd0, mem_in_data}, {12'd0, e.data});
            end
         end
         if (done) begin
            done_count++;
            done_cyc   = cyc;
            done_err   = error;
            done_words = words_loaded;
         end
      end
   end

   // Queue the three bytes of a word and the write it should produce.
   task automatic addWord(input logic [4:0] addr, input logic [19:0] w, input bit expect_write);
      byte_q.push_back(w[7:0]);
      byte_q.push_back(w[15:8]);
      byte_q.push_back({4'h0, w[19:16]});
      if (expect_write) sb_q.push_back('{addr: addr, data: w});
   endtask

   // Start a load and feed byte_q. max_gap adds random idle cycles before
   // each byte, poke_start pulses start (with a different length) while the
   // loader is busy, and abort_after stops feeding once that many bytes
   // have been accepted (0 = feed everything).
   task automatic applyStimulus(input logic [5:0] len, input int max_gap,
                                input bit poke_start, input int abort_after);
      int  accepted;
      int  t;
      bit  acc;
      @(negedge clk);
      start     = 1'b1;
      load_len  = len;
      start_cyc = cyc;
      @(negedge clk);
      start    = 1'b0;
      accepted = 0;
      for (int i = 0; i < byte_q.size(); i++) begin
         if (poke_start && i == 1) begin
            byte_valid = 1'b0;
            start      = 1'b1;
            load_len   = 6'd5;
            @(negedge clk);
            start = 1'b0;
         end
         if (max_gap > 0) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
         end
         byte_valid = 1'b1;
         byte_data  = byte_q[i];
         t = 0;
         do begin
            acc = byte_ready;
            @(negedge clk);
            t++;
         end while (!acc && t < 64);
         if (!acc) begin
            checkOutput("byte_accept_timeout", 32'd1, 32'd0);
            break;
         end
         accepted++;
         if (abort_after != 0 && accepted == abort_after) break;
      end
      byte_valid = 1'b0;
      byte_q.delete();
   endtask

   task automatic waitDone(input int prev);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (done_count != prev) return;
      end
      checkOutput("done_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int          en0;
      int          d0;
      logic [19:0] w;
      logic [5:0]  bad_lens[2];

      rst        = 1'b1;
      start      = 1'b1;
      load_len   = 6'd2;
      byte_valid = 1'b0;
      byte_data  = 8'h00;

      // Reset held two cycles with start high: rst must win.
      repeat (2) @(negedge clk);
      checkOutput("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      checkOutput("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
      checkOutput("rst_rw_select", {31'd0, mem_read_writenot}, 32'd1);
      checkOutput("rst_addr", {27'd0, mem_write_address}, 32'd0);
      checkOutput("rst_data", {12'd0, mem_in_data}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_error", {31'd0, error}, 32'd0);
      checkOutput("rst_words", {26'd0, words_loaded}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;

      // Two-word load with back-to-back bytes.
      byte_q = '{8'h34, 8'h12, 8'h05, 8'hCD, 8'hAB, 8'h0F};
      sb_q.push_back('{addr: 5'd0, data: 20'h51234});
      sb_q.push_back('{addr: 5'd1, data: 20'hFABCD});
      en0 = en_count; d0 = done_count;
      applyStimulus(6'd2, 0, 1'b0, 0);
      waitDone(d0);
      checkOutput("two_done_cycle", done_cyc, start_cyc + 9);
      checkOutput("two_words", {26'd0, done_words}, 32'd2);
      checkOutput("two_error", {31'd0, done_err}, 32'd0);
      checkOutput("two_writes", en_count - en0, 32'd2);
      @(negedge clk);
      checkOutput("two_busy_after", {31'd0, busy}, 32'd0);

      // Same image with a stalling source.
      for (int rep = 0; rep < 3; rep++) begin
         byte_q = '{8'h34, 8'h12, 8'h05, 8'hCD, 8'hAB, 8'h0F};
         sb_q.push_back('{addr: 5'd0, data: 20'h51234});
         sb_q.push_back('{addr: 5'd1, data: 20'hFABCD});
         en0 = en_count; d0 = done_count;
         applyStimulus(6'd2, 3, 1'b0, 0);
         waitDone(d0);
         checkOutput("stall_writes", en_count - en0, 32'd2);
         checkOutput("stall_words", {26'd0, done_words}, 32'd2);
      end

      // Non-zero high nibble in the third byte.
      byte_q = '{8'h11, 8'h22, 8'hF3};
      sb_q.push_back('{addr: 5'd0, data: 20'h32211});
      d0 = done_count;
      applyStimulus(6'd1, 0, 1'b0, 0);
      waitDone(d0);
      checkOutput("nibble_error", {31'd0, done_err}, 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("nibble_sticky", {31'd0, error}, 32'd1);
      checkOutput("nibble_idle", {31'd0, busy}, 32'd0);

      // A clean load afterwards clears the flag.
      addWord(5'd0, 20'h30201, 1'b1);
      d0 = done_count;
      applyStimulus(6'd1, 0, 1'b0, 0);
      waitDone(d0);
      checkOutput("clean_error", {31'd0, done_err}, 32'd0);

      // Illegal lengths.
      bad_lens[0] = 6'd0;
      bad_lens[1] = 6'd33;
      for (int i = 0; i < 2; i++) begin
         en0 = en_count; d0 = done_count;
         applyStimulus(bad_lens[i], 0, 1'b0, 0);
         waitDone(d0);
         checkOutput("bad_done_cycle", done_cyc, start_cyc + 1);
         checkOutput("bad_error", {31'd0, done_err}, 32'd1);
         checkOutput("bad_writes", en_count - en0, 32'd0);
         checkOutput("bad_words", {26'd0, done_words}, 32'd0);
      end

      // Full-depth load of random words.
      for (int i = 0; i < 32; i++) begin
         w = 20'($urandom);
         addWord(5'(i), w, 1'b1);
      end
      en0 = en_count; d0 = done_count;
      applyStimulus(6'd32, 0, 1'b0, 0);
      waitDone(d0);
      checkOutput("full_done_cycle", done_cyc, start_cyc + 129);
      checkOutput("full_words", {26'd0, done_words}, 32'd32);
      checkOutput("full_writes", en_count - en0, 32'd32);
      checkOutput("full_error", {31'd0, done_err}, 32'd0);

      // Reset during the third word: only the first two words are written.
      addWord(5'd0, 20'hA1B2C, 1'b1);
      addWord(5'd1, 20'h3D4E5, 1'b1);
      addWord(5'd2, 20'h6F708, 1'b0);
      en0 = en_count;
      applyStimulus(6'd4, 0, 1'b0, 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_ready", {31'd0, byte_ready}, 32'd0);
      checkOutput("abort_words", {26'd0, words_loaded}, 32'd0);
      checkOutput("abort_rw_select", {31'd0, mem_read_writenot}, 32'd1);
      checkOutput("abort_addr", {27'd0, mem_write_address}, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("abort_writes", en_count - en0, 32'd2);

      // start pulsed while busy is ignored and the length is not re-sampled.
      addWord(5'd0, 20'h13579, 1'b1);
      addWord(5'd1, 20'h2468A, 1'b1);
      en0 = en_count; d0 = done_count;
      applyStimulus(6'd2, 0, 1'b1, 0);
      waitDone(d0);
      checkOutput("poke_words", {26'd0, done_words}, 32'd2);
      checkOutput("poke_writes", en_count - en0, 32'd2);
      repeat (3) @(negedge clk);
      checkOutput("poke_idle", {31'd0, busy}, 32'd0);

      checkOutput("sb_leftover", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
